// File: rtl/jtroadf_sdram_arb.sv
// jtroadf_sdram_arb
// Shares the single SDRAM read port between N ROM requesters. Each slot keeps
// a one-word tag/data cache. A hit raises slot_ok combinationally in the same
// cycle. Misses are served one at a time, and the highest slot index has
// priority.
//
// Ports
//   clk, rst          SDRAM clock; synchronous active-high reset
//   downloading       ROM download in progress: invalidates caches, blocks reads
//   slot_cs           per-slot level-sensitive read request
//   slot_addr         per-slot word address, slot i at [i*AW +: AW]
//   slot_ok           slot data valid for the current slot address
//   slot_dout         per-slot cached word, slot i at [i*DW +: DW]
//   sdram_req/addr    read request towards the SDRAM controller
//   sdram_ack         request accepted (one-cycle pulse)
//   data_dst          first data beat on bus (not used)
//   data_rdy          data_read valid (one-cycle pulse)
//   data_read         SDRAM read data
module jtroadf_sdram_arb #(
    parameter int N  = 5,
    parameter int AW = 22,
    parameter int DW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            downloading,
    input  logic [N-1:0]    slot_cs,
    input  logic [N*AW-1:0] slot_addr,
    output logic [N-1:0]    slot_ok,
    output logic [N*DW-1:0] slot_dout,
    output logic            sdram_req,
    output logic [AW-1:0]   sdram_addr,
    input  logic            sdram_ack,
    input  logic            data_dst,
    input  logic            data_rdy,
    input  logic [DW-1:0]   data_read
);

    localparam int SW = $clog2(N);

    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_RDY} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic            req_q, req_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [N-1:0]    valid_q;
    logic [AW-1:0]   tag_q  [N];
    logic [DW-1:0]   data_q [N];

    logic [N-1:0]    miss;
    logic [SW-1:0]   pick;
    logic [AW-1:0]   pick_addr;
    logic            fill;

    logic            unused_data_dst;
    assign unused_data_dst = data_dst;

    assign sdram_req  = req_q;
    assign sdram_addr = addr_q;

    // Cache lookup: hits are combinational so ok rises in the same cycle.
    always_comb begin
        slot_ok   = '0;
        slot_dout = '0;
        miss      = '0;
        for (int unsigned i = 0; i < N; i++) begin
            slot_ok[i]            = slot_cs[i] & valid_q[i] &
                                    (slot_addr[i*AW +: AW] == tag_q[i]);
            slot_dout[i*DW +: DW] = data_q[i];
            miss[i]               = slot_cs[i] & ~slot_ok[i];
        end
    end

    // Fixed priority: the ascending scan lets the highest missing index win.
    always_comb begin
        pick      = '0;
        pick_addr = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (miss[i]) begin
                pick      = SW'(i);
                pick_addr = slot_addr[i*AW +: AW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        req_d   = req_q;
        addr_d  = addr_q;
        fill    = 1'b0;
        if (downloading) begin
            state_d = IDLE;
            req_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|miss) begin
                        sel_d   = pick;
                        addr_d  = pick_addr;
                        req_d   = 1'b1;
                        state_d = WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (sdram_ack) begin
                        req_d = 1'b0;
                        // Data may come back in the same cycle as the ack.
                        if (data_rdy) begin
                            fill    = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = WAIT_RDY;
                        end
                    end
                end
                WAIT_RDY: begin
                    if (data_rdy) begin
                        fill    = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            valid_q <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            if (downloading) begin
                valid_q <= '0;
            end else if (fill) begin
                // Tag with the issued address, not the live slot address.
                valid_q[sel_q] <= 1'b1;
                tag_q[sel_q]   <= addr_q;
                data_q[sel_q]  <= data_read;
            end
        end
    end

endmodule
